imem_arbiter: RTL and testbench

- Shares the single combinational-read instruction memory (DEPTH x BITS) between two requesters: the core fetch unit and the program loader/debug port.
- Registers each granted access and returns the read data one cycle later.
- Provides a loader lock mode so a program image can be written while fetch is stalled.
- Sits between the fetch stage / loader and the instruction memory instance.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_arb_prio.sv | 54 +++++
 rtl/imem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and default sizes for the instruction-memory arbiter.
package imem_pkg;

  localparam int DEF_DEPTH      = 32;
  localparam int DEF_BITS       = 64;
  localparam int DEF_MAX_STARVE = 4;

  // Arbiter operating mode: normal sharing, one-cycle drain, exclusive loader.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Winner of the memory port in the current cycle.
  typedef enum logic [1:0] {
    G_NONE  = 2'd0,
    G_FETCH = 2'd1,
    G_LOAD  = 2'd2
  } grant_t;

endpackage

// File: rtl/imem_arb_prio.sv
// Combinational winner select between fetch and loader, with a saturating
// starvation counter that forces a fetch grant after MAX_STARVE consecutive
// loader wins while fetch is waiting.
module imem_arb_prio
  import imem_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   f_en,
  input  logic   l_en,
  input  logic   f_valid,
  input  logic   l_valid,
  output grant_t grant
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // Pick the winner; loader has priority unless fetch has waited too long.
  always_comb begin
    grant = G_NONE;
    if (l_en && l_valid && f_en && f_valid) begin
      grant = (starve_q == STARVE_MAX) ? G_FETCH : G_LOAD;
    end else if (l_en && l_valid) begin
      grant = G_LOAD;
    end else if (f_en && f_valid) begin
      grant = G_FETCH;
    end
  end

  // Count loader wins while fetch waits; clear when fetch is served or idle.
  always_comb begin
    starve_d = starve_q;
    if (!f_valid || grant == G_FETCH) begin
      starve_d = '0;
    end else if (grant == G_LOAD && starve_q < STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational-read instruction memory between the fetch unit
// and the loader/debug port. Grants are combinational, read data is
// registered, so responses arrive one cycle after the grant. A loader lock
// mode drains the in-flight access and then blocks fetch entirely.
// Optional performance counters are enabled with `define IMEM_ARB_PERF_EN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int BITS       = DEF_BITS,
  parameter  int MAX_STARVE = DEF_MAX_STARVE,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_req_valid,
  output logic            f_req_ready,
  input  logic [AW-1:0]   f_addr,
  output logic            f_rsp_valid,
  output logic [BITS-1:0] f_rsp_data,
  input  logic            l_req_valid,
  output logic            l_req_ready,
  input  logic [AW-1:0]   l_addr,
  input  logic            l_we,
  input  logic [BITS-1:0] l_wdata,
  input  logic            l_lock,
  output logic            l_locked,
  output logic            l_rsp_valid,
  output logic [BITS-1:0] l_rsp_data,
  output logic [AW-1:0]   mem_address,
  output logic            mem_we,
  output logic [BITS-1:0] mem_wdata,
  input  logic [BITS-1:0] mem_readData
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_f_grants,
  output logic [31:0]     perf_l_grants,
  output logic [31:0]     perf_f_stall
`endif
);

  state_t          state_q, state_d;
  grant_t          grant;
  logic [AW-1:0]   addr_q, addr_d;
  logic            f_rsp_valid_q, f_rsp_valid_d;
  logic [BITS-1:0] f_rsp_data_q, f_rsp_data_d;
  logic            l_rsp_valid_q, l_rsp_valid_d;
  logic [BITS-1:0] l_rsp_data_q, l_rsp_data_d;

  imem_arb_prio #(
    .MAX_STARVE(MAX_STARVE)
  ) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .f_en   (state_q == RUN),
    .l_en   (state_q != DRAIN),
    .f_valid(f_req_valid),
    .l_valid(l_req_valid),
    .grant  (grant)
  );

  // Mode FSM: a lock request drains one cycle, then holds until released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (l_lock) state_d = DRAIN;
      DRAIN:   state_d = LOCK;
      LOCK:    if (!l_lock) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Handshakes and memory port; the address holds when nobody is granted.
  always_comb begin
    f_req_ready = (grant == G_FETCH);
    l_req_ready = (grant == G_LOAD);
    l_locked    = (state_q == LOCK);
    mem_address = addr_q;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (grant)
      G_FETCH: mem_address = f_addr;
      G_LOAD: begin
        mem_address = l_addr;
        mem_we      = l_we;
        mem_wdata   = l_wdata;
      end
      default: ;
    endcase
    addr_d = mem_address;
  end

  // Response capture: read data is sampled at the edge ending the grant cycle.
  always_comb begin
    f_rsp_valid_d = (grant == G_FETCH);
    l_rsp_valid_d = (grant == G_LOAD);
    f_rsp_data_d  = f_rsp_data_q;
    l_rsp_data_d  = l_rsp_data_q;
    if (grant == G_FETCH) begin
      f_rsp_data_d = mem_readData;
    end
    if (grant == G_LOAD) begin
      l_rsp_data_d = l_we ? '0 : mem_readData;
    end
  end

  // State, held address and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      addr_q        <= '0;
      f_rsp_valid_q <= 1'b0;
      f_rsp_data_q  <= '0;
      l_rsp_valid_q <= 1'b0;
      l_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      f_rsp_data_q  <= f_rsp_data_d;
      l_rsp_valid_q <= l_rsp_valid_d;
      l_rsp_data_q  <= l_rsp_data_d;
    end
  end

  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rsp_data  = f_rsp_data_q;
  assign l_rsp_valid = l_rsp_valid_q;
  assign l_rsp_data  = l_rsp_data_q;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_f_grants_q, perf_f_grants_d;
  logic [31:0] perf_l_grants_q, perf_l_grants_d;
  logic [31:0] perf_f_stall_q, perf_f_stall_d;

  // Free-running grant and stall counters, wrapping at 2^32.
  always_comb begin
    perf_f_grants_d = perf_f_grants_q + ((grant == G_FETCH) ? 32'd1 : 32'd0);
    perf_l_grants_d = perf_l_grants_q + ((grant == G_LOAD) ? 32'd1 : 32'd0);
    perf_f_stall_d  = perf_f_stall_q + ((f_req_valid && !f_req_ready) ? 32'd1 : 32'd0);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_f_grants_q <= '0;
      perf_l_grants_q <= '0;
      perf_f_stall_q  <= '0;
    end else begin
      perf_f_grants_q <= perf_f_grants_d;
      perf_l_grants_q <= perf_l_grants_d;
      perf_f_stall_q  <= perf_f_stall_d;
    end
  end

  assign perf_f_grants = perf_f_grants_q;
  assign perf_l_grants = perf_l_grants_q;
  assign perf_f_stall  = perf_f_stall_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: table-driven single-cycle vectors
// plus hand-written sequences for starvation, lock and mid-access reset.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [4:0]  f_addr;
  logic        f_rsp_valid;
  logic [63:0] f_rsp_data;
  logic        l_req_valid;
  logic        l_req_ready;
  logic [4:0]  l_addr;
  logic        l_we;
  logic [63:0] l_wdata;
  logic        l_lock;
  logic        l_locked;
  logic        l_rsp_valid;
  logic [63:0] l_rsp_data;
  logic [4:0]  mem_address;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_readData;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_f_grants;
  logic [31:0] perf_l_grants;
  logic [31:0] perf_f_stall;
`endif

  imem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req_valid (f_req_valid),
    .f_req_ready (f_req_ready),
    .f_addr      (f_addr),
    .f_rsp_valid (f_rsp_valid),
    .f_rsp_data  (f_rsp_data),
    .l_req_valid (l_req_valid),
    .l_req_ready (l_req_ready),
    .l_addr      (l_addr),
    .l_we        (l_we),
    .l_wdata     (l_wdata),
    .l_lock      (l_lock),
    .l_locked    (l_locked),
    .l_rsp_valid (l_rsp_valid),
    .l_rsp_data  (l_rsp_data),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_readData(mem_readData)
`ifdef IMEM_ARB_PERF_EN
    ,
    .perf_f_grants(perf_f_grants),
    .perf_l_grants(perf_l_grants),
    .perf_f_stall (perf_f_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Initial image of every word, known to the bench independently of the DUT.
  function automatic logic [63:0] w(input int a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h1111);
  endfunction

  // Behavioural memory: combinational read, synchronous write.
  logic [63:0] mem [32];
  logic        mem_ready;
  assign mem_readData = mem[mem_address];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= w(i);
    end else if (mem_we) begin
      mem[mem_address] <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [4:0] fa, input logic lv,
                       input logic [4:0] la, input logic lwe, input logic [63:0] lwd,
                       input logic lock);
    @(negedge clk);
    f_req_valid = fv;
    f_addr      = fa;
    l_req_valid = lv;
    l_addr      = la;
    l_we        = lwe;
    l_wdata     = lwd;
    l_lock      = lock;
  endtask

  typedef struct {
    logic        fv;
    logic [4:0]  fa;
    logic        lv;
    logic [4:0]  la;
    logic        lwe;
    logic [63:0] lwd;
    logic        lock;
    logic        e_fr;
    logic        e_lr;
    logic        e_frv;
    logic [63:0] e_frd;
    logic        e_lrv;
    logic [63:0] e_lrd;
    logic        e_lkd;
    logic        e_we;
  } vec_t;

  function automatic vec_t mk(input logic fv, input logic [4:0] fa, input logic lv,
                              input logic [4:0] la, input logic lwe, input logic [63:0] lwd,
                              input logic lock, input logic e_fr, input logic e_lr,
                              input logic e_frv, input logic [63:0] e_frd,
                              input logic e_lrv, input logic [63:0] e_lrd,
                              input logic e_lkd, input logic e_we);
    vec_t v;
    v.fv = fv; v.fa = fa; v.lv = lv; v.la = la; v.lwe = lwe; v.lwd = lwd; v.lock = lock;
    v.e_fr = e_fr; v.e_lr = e_lr; v.e_frv = e_frv; v.e_frd = e_frd;
    v.e_lrv = e_lrv; v.e_lrd = e_lrd; v.e_lkd = e_lkd; v.e_we = e_we;
    return v;
  endfunction

  localparam logic [63:0] DB = 64'hDEADBEEF_0000_0003;
  localparam logic [63:0] LW = 64'h0123_4567_89AB_CDEF;

  vec_t vecs[$];
  logic prev_f;
  logic exp_f;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0;
    f_req_valid = 0; f_addr = 0; l_req_valid = 0; l_addr = 0;
    l_we = 0; l_wdata = 0; l_lock = 0;
    #1;
    chk("reset f_rsp_valid", 64'(f_rsp_valid), 64'd0);
    chk("reset l_rsp_valid", 64'(l_rsp_valid), 64'd0);
    chk("reset f_rsp_data", f_rsp_data, 64'd0);
    chk("reset l_rsp_data", l_rsp_data, 64'd0);
    chk("reset l_locked", 64'(l_locked), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    #11;
    rst_n = 1'b1; mem_ready = 1'b1;

    // Fetch-only burst, loader write then fetch read-back, loader read, conflict.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(1, 5'(i), 0, 0, 0, 0, 0,  1, 0, 1, w(i - 1), 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, w(7), 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 1, DB, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, DB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, w(5), 0, 0));
    vecs.push_back(mk(1, 2, 1, 4, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, w(4), 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, w(2), 0, 0, 0, 0));

    foreach (vecs[k]) begin
      drive(vecs[k].fv, vecs[k].fa, vecs[k].lv, vecs[k].la, vecs[k].lwe, vecs[k].lwd, vecs[k].lock);
      #1;
      $display("vec %0d: f_ready=%0b l_ready=%0b f_rsp=%0b/%h l_rsp=%0b/%h", k,
               f_req_ready, l_req_ready, f_rsp_valid, f_rsp_data, l_rsp_valid, l_rsp_data);
      chk($sformatf("vec%0d f_req_ready", k), 64'(f_req_ready), 64'(vecs[k].e_fr));
      chk($sformatf("vec%0d l_req_ready", k), 64'(l_req_ready), 64'(vecs[k].e_lr));
      chk($sformatf("vec%0d f_rsp_valid", k), 64'(f_rsp_valid), 64'(vecs[k].e_frv));
      chk($sformatf("vec%0d l_rsp_valid", k), 64'(l_rsp_valid), 64'(vecs[k].e_lrv));
      chk($sformatf("vec%0d l_locked", k), 64'(l_locked), 64'(vecs[k].e_lkd));
      chk($sformatf("vec%0d mem_we", k), 64'(mem_we), 64'(vecs[k].e_we));
      if (vecs[k].e_frv) chk($sformatf("vec%0d f_rsp_data", k), f_rsp_data, vecs[k].e_frd);
      if (vecs[k].e_lrv) chk($sformatf("vec%0d l_rsp_data", k), l_rsp_data, vecs[k].e_lrd);
    end

    // Both requesters valid continuously: L,L,L,L,F repeating.
    prev_f = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 1, 6, 0, 0, 0);
      #1;
      exp_f = ((k % 5) == 4);
      $display("starve cycle %0d: f_ready=%0b l_ready=%0b", k, f_req_ready, l_req_ready);
      chk($sformatf("starve%0d f_req_ready", k), 64'(f_req_ready), 64'(exp_f));
      chk($sformatf("starve%0d l_req_ready", k), 64'(l_req_ready), 64'(!exp_f));
      if (k > 0) begin
        chk($sformatf("starve%0d f_rsp_valid", k), 64'(f_rsp_valid), 64'(prev_f));
        chk($sformatf("starve%0d l_rsp_valid", k), 64'(l_rsp_valid), 64'(!prev_f));
        if (prev_f) chk($sformatf("starve%0d f_rsp_data", k), f_rsp_data, w(1));
        else        chk($sformatf("starve%0d l_rsp_data", k), l_rsp_data, w(6));
      end
      prev_f = exp_f;
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Lock while fetch is busy: RUN grant, DRAIN, LOCK with loader traffic, unlock.
    drive(1, 0, 0, 0, 0, 0, 1); #1;
    $display("lock c0: f_ready=%0b locked=%0b", f_req_ready, l_locked);
    chk("lock c0 f_req_ready", 64'(f_req_ready), 64'd1);
    chk("lock c0 l_locked", 64'(l_locked), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 1); #1;
    $display("lock c1 (drain): f_ready=%0b l_ready=%0b locked=%0b", f_req_ready, l_req_ready, l_locked);
    chk("drain f_req_ready", 64'(f_req_ready), 64'd0);
    chk("drain l_req_ready", 64'(l_req_ready), 64'd0);
    chk("drain l_locked", 64'(l_locked), 64'd0);
    chk("drain f_rsp_valid", 64'(f_rsp_valid), 64'd1);
    chk("drain f_rsp_data", f_rsp_data, w(0));
    drive(1, 0, 1, 9, 1, LW, 1); #1;
    $display("lock c2: locked=%0b f_ready=%0b l_ready=%0b", l_locked, f_req_ready, l_req_ready);
    chk("lock c2 l_locked", 64'(l_locked), 64'd1);
    chk("lock c2 f_req_ready", 64'(f_req_ready), 64'd0);
    chk("lock c2 l_req_ready", 64'(l_req_ready), 64'd1);
    chk("lock c2 mem_we", 64'(mem_we), 64'd1);
    chk("lock c2 f_rsp_valid", 64'(f_rsp_valid), 64'd0);
    drive(1, 0, 1, 9, 0, 0, 1); #1;
    $display("lock c3: l_ready=%0b l_rsp=%0b/%h", l_req_ready, l_rsp_valid, l_rsp_data);
    chk("lock c3 l_req_ready", 64'(l_req_ready), 64'd1);
    chk("lock c3 f_req_ready", 64'(f_req_ready), 64'd0);
    chk("lock c3 l_rsp_valid", 64'(l_rsp_valid), 64'd1);
    chk("lock c3 l_rsp_data", l_rsp_data, 64'd0);
    drive(1, 0, 0, 0, 0, 0, 1); #1;
    $display("lock c4: l_rsp=%0b/%h", l_rsp_valid, l_rsp_data);
    chk("lock c4 l_locked", 64'(l_locked), 64'd1);
    chk("lock c4 f_req_ready", 64'(f_req_ready), 64'd0);
    chk("lock c4 l_rsp_valid", 64'(l_rsp_valid), 64'd1);
    chk("lock c4 l_rsp_data", l_rsp_data, LW);
    drive(1, 0, 0, 0, 0, 0, 0); #1;
    $display("lock c5 (release): locked=%0b f_ready=%0b", l_locked, f_req_ready);
    chk("lock c5 l_locked", 64'(l_locked), 64'd1);
    chk("lock c5 f_req_ready", 64'(f_req_ready), 64'd0);
    drive(1, 7, 0, 0, 0, 0, 0); #1;
    $display("lock c6 (run): locked=%0b f_ready=%0b", l_locked, f_req_ready);
    chk("unlock l_locked", 64'(l_locked), 64'd0);
    chk("unlock f_req_ready", 64'(f_req_ready), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("unlock f_rsp_valid", 64'(f_rsp_valid), 64'd1);
    chk("unlock f_rsp_data", f_rsp_data, w(7));

    // Reset while a fetch response is pending in the output register.
    drive(1, 4, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre-reset f_rsp_valid", 64'(f_rsp_valid), 64'd1);
    rst_n = 1'b0; f_req_valid = 1'b0;
    #1;
    $display("mid reset: f_rsp=%0b/%h locked=%0b we=%0b", f_rsp_valid, f_rsp_data, l_locked, mem_we);
    chk("mid-reset f_rsp_valid", 64'(f_rsp_valid), 64'd0);
    chk("mid-reset f_rsp_data", f_rsp_data, 64'd0);
    chk("mid-reset l_rsp_valid", 64'(l_rsp_valid), 64'd0);
    chk("mid-reset l_locked", 64'(l_locked), 64'd0);
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("post-reset f_rsp_valid a", 64'(f_rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("post-reset f_rsp_valid b", 64'(f_rsp_valid), 64'd0);
    drive(1, 4, 0, 0, 0, 0, 0); #1;
    chk("post-reset f_req_ready", 64'(f_req_ready), 64'd1);

`ifdef IMEM_ARB_PERF_EN
    // Counters restart at the reset above: 10 fetch and 6 loader grants in total.
    for (int k = 0; k < 5; k++) drive(1, 2, 1, 8, 0, 0, 0);
    for (int k = 0; k < 8; k++) drive(1, 2, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) drive(0, 0, 1, 8, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    $display("perf: f=%0d l=%0d stall=%0d", perf_f_grants, perf_l_grants, perf_f_stall);
    chk("perf_f_grants", 64'(perf_f_grants), 64'd10);
    chk("perf_l_grants", 64'(perf_l_grants), 64'd6);
    chk("perf_f_stall", 64'(perf_f_stall), 64'd4);
`endif

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
